// File: rtl/adc_iq_detector_pkg.sv
// Shared constants, FSM state encoding and sample conversion for the ADC I/Q detector.
package adc_iq_pkg;

  localparam int unsigned ADC_WIDTH_DEF  = 12;
  localparam int unsigned REF_WIDTH_DEF  = 16;
  localparam int unsigned ACC_WIDTH_DEF  = 48;
  localparam int unsigned SETTLE_LEN_DEF = 16;

  // Cycles spent in DRAIN so the last accepted sample clears the 3-stage MAC pipeline.
  localparam int unsigned DRAIN_CYCLES = 3;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StSettle = 3'd1;
  localparam state_t StAccum  = 3'd2;
  localparam state_t StDrain  = 3'd3;
  localparam state_t StDone   = 3'd4;

  // Offset-binary code to two's complement: subtract mid-code 2^(width-1).
  function automatic logic signed [31:0] to_signed_sample(input logic [31:0] code,
                                                          input int unsigned width);
    return $signed(code - (32'd1 << (width - 1)));
  endfunction

endpackage

// File: rtl/adc_iq_detector_if.sv
// Sample, control and result signals of the ADC I/Q detector.
// clip_count exists only when ADC_CLIP_DET_EN is defined.
interface adc_iq_detector_if #(
  parameter int unsigned ADC_WIDTH = 12,
  parameter int unsigned REF_WIDTH = 16,
  parameter int unsigned ACC_WIDTH = 48
);

  logic        [ADC_WIDTH-1:0] adc_data;
  logic signed [REF_WIDTH-1:0] ref_cos;
  logic signed [REF_WIDTH-1:0] ref_sin;
  logic                        ref_valid;
  logic                        start;
  logic        [31:0]          sample_count;
  logic                        busy;
  logic                        result_valid;
  logic                        result_ready;
  logic signed [ACC_WIDTH-1:0] i_acc;
  logic signed [ACC_WIDTH-1:0] q_acc;
  logic                        overflow;
`ifdef ADC_CLIP_DET_EN
  logic        [31:0]          clip_count;
`endif

  // Driver side (sample source and readout logic).
  modport master (
    output adc_data, ref_cos, ref_sin, ref_valid, start, sample_count, result_ready,
    input  busy, result_valid, i_acc, q_acc, overflow
`ifdef ADC_CLIP_DET_EN
    , input clip_count
`endif
  );

  // Detector side.
  modport slave (
    input  adc_data, ref_cos, ref_sin, ref_valid, start, sample_count, result_ready,
    output busy, result_valid, i_acc, q_acc, overflow
`ifdef ADC_CLIP_DET_EN
    , output clip_count
`endif
  );

endinterface

// File: rtl/adc_iq_detector_mac_lane.sv
// One demodulation lane: registered product, sign-extend, wrapping accumulate, sticky overflow.
module iq_mac_lane #(
  parameter int unsigned ADC_WIDTH = 12,
  parameter int unsigned REF_WIDTH = 16,
  parameter int unsigned ACC_WIDTH = 48
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr_i,
  input  logic signed [ADC_WIDTH-1:0] sample_i,
  input  logic signed [REF_WIDTH-1:0] ref_i,
  input  logic                        load_i,
  input  logic                        add_i,
  output logic signed [ACC_WIDTH-1:0] acc_o,
  output logic                        ovf_o
);

  localparam int unsigned ProdWidth = ADC_WIDTH + REF_WIDTH;

  logic signed [ProdWidth-1:0] prod_d, prod_q;
  logic signed [ACC_WIDTH-1:0] acc_d, acc_q;
  logic signed [ACC_WIDTH-1:0] addend;
  logic signed [ACC_WIDTH-1:0] sum;
  logic                        ovf_d, ovf_q;

  // Product stage and accumulate stage next-state.
  always_comb begin
    prod_d = prod_q;
    if (load_i) begin
      prod_d = ProdWidth'(sample_i) * ProdWidth'(ref_i);
    end
    addend = ACC_WIDTH'(prod_q);
    sum    = acc_q + addend;
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    if (clr_i) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (add_i) begin
      acc_d = sum;
      // Same-sign addends producing an opposite-sign sum means the accumulator wrapped.
      if ((acc_q[ACC_WIDTH-1] == addend[ACC_WIDTH-1]) &&
          (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1])) begin
        ovf_d = 1'b1;
      end
    end
  end

  // Lane state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/adc_iq_detector.sv
// Coherent I/Q detector: multiplies ADC samples by the DDS cos/sin reference and sums them
// over a programmed sample count. Optional clip counter enabled by defining ADC_CLIP_DET_EN.
module adc_iq_detector
  import adc_iq_pkg::*;
#(
  parameter int unsigned ADC_WIDTH  = ADC_WIDTH_DEF,
  parameter int unsigned REF_WIDTH  = REF_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int unsigned SETTLE_LEN = SETTLE_LEN_DEF
) (
  input logic              clk,
  input logic              rst,
  adc_iq_detector_if.slave bus
);

  state_t      state_d, state_q;
  logic [31:0] rem_d, rem_q;
  logic [31:0] settle_d, settle_q;
  logic [1:0]  drain_d, drain_q;
  logic        clr;
  logic        accept;

  logic signed [ADC_WIDTH-1:0] s1_sample_d, s1_sample_q;
  logic signed [REF_WIDTH-1:0] s1_cos_d, s1_cos_q;
  logic signed [REF_WIDTH-1:0] s1_sin_d, s1_sin_q;
  logic                        s1_valid_q, s2_valid_q;

  logic signed [ACC_WIDTH-1:0] i_acc, q_acc;
  logic                        i_ovf, q_ovf;

  assign accept = (state_q == StAccum) && bus.ref_valid;

  // Measurement sequencing: settle, accumulate, drain the pipeline, hold the result.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    settle_d = settle_q;
    drain_d  = drain_q;
    clr      = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          clr      = 1'b1;
          rem_d    = bus.sample_count;
          settle_d = '0;
          drain_d  = '0;
          if (bus.sample_count == 32'd0) begin
            state_d = StDone;
          end else if (SETTLE_LEN == 0) begin
            state_d = StAccum;
          end else begin
            state_d = StSettle;
          end
        end
      end
      StSettle: begin
        if (bus.ref_valid) begin
          if (settle_q == 32'(SETTLE_LEN - 1)) begin
            state_d = StAccum;
          end else begin
            settle_d = settle_q + 32'd1;
          end
        end
      end
      StAccum: begin
        if (bus.ref_valid) begin
          rem_d = rem_q - 32'd1;
          if (rem_q == 32'd1) begin
            state_d = StDrain;
            drain_d = '0;
          end
        end
      end
      StDrain: begin
        if (drain_q == 2'(DRAIN_CYCLES - 1)) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      StDone: begin
        if (bus.result_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      rem_q    <= '0;
      settle_q <= '0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      settle_q <= settle_d;
      drain_q  <= drain_d;
    end
  end

  // Stage 1 input capture; only accepted samples are loaded.
  always_comb begin
    s1_sample_d = s1_sample_q;
    s1_cos_d    = s1_cos_q;
    s1_sin_d    = s1_sin_q;
    if (accept) begin
      s1_sample_d = ADC_WIDTH'(to_signed_sample(32'(bus.adc_data), ADC_WIDTH));
      s1_cos_d    = bus.ref_cos;
      s1_sin_d    = bus.ref_sin;
    end
  end

  // Shared valid pipeline; a zero marks a bubble that never adds.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sample_q <= '0;
      s1_cos_q    <= '0;
      s1_sin_q    <= '0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
    end else begin
      s1_sample_q <= s1_sample_d;
      s1_cos_q    <= s1_cos_d;
      s1_sin_q    <= s1_sin_d;
      s1_valid_q  <= accept;
      s2_valid_q  <= s1_valid_q;
    end
  end

  iq_mac_lane #(
    .ADC_WIDTH(ADC_WIDTH),
    .REF_WIDTH(REF_WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_lane_i (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr),
    .sample_i(s1_sample_q),
    .ref_i   (s1_cos_q),
    .load_i  (s1_valid_q),
    .add_i   (s2_valid_q),
    .acc_o   (i_acc),
    .ovf_o   (i_ovf)
  );

  iq_mac_lane #(
    .ADC_WIDTH(ADC_WIDTH),
    .REF_WIDTH(REF_WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_lane_q (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr),
    .sample_i(s1_sample_q),
    .ref_i   (s1_sin_q),
    .load_i  (s1_valid_q),
    .add_i   (s2_valid_q),
    .acc_o   (q_acc),
    .ovf_o   (q_ovf)
  );

  assign bus.busy         = (state_q != StIdle);
  assign bus.result_valid = (state_q == StDone);
  assign bus.i_acc        = i_acc;
  assign bus.q_acc        = q_acc;
  assign bus.overflow     = i_ovf | q_ovf;

`ifdef ADC_CLIP_DET_EN
  logic [31:0] clip_d, clip_q;
  logic        clip_hit;

  // Count accepted full-scale codes; saturating.
  always_comb begin
    clip_d   = clip_q;
    clip_hit = (bus.adc_data == '0) || (bus.adc_data == '1);
    if (clr) begin
      clip_d = '0;
    end else if (accept && clip_hit && (clip_q != 32'hFFFF_FFFF)) begin
      clip_d = clip_q + 32'd1;
    end
  end

  // Clip counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      clip_q <= '0;
    end else begin
      clip_q <= clip_d;
    end
  end

  assign bus.clip_count = clip_q;
`endif

endmodule
